ex_ip_access: RTL and testbench

- Execute/memory-access stage directly downstream of the ID/EX register in IP mode.
- Consumes the registered address, data-memory read/write and enable, and IP read/write strobes.
- Performs either a fixed-latency data-memory access or a req/ack handshake to the IP peripheral.
- Drives `stall` back to the ID/EX register's hold input until the access completes, and returns read data with a one-cycle valid strobe.

---
 rtl/ex_ip_access.sv | 170 +++++++++++++++++
 tb/tb_ex_ip_access.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_ip_access.sv
// Execute/memory-access stage: fixed-latency data-memory access or req/ack IP access.
// Optional IP handshake watchdog enabled by defining IP_TIMEOUT_EN.
module ex_ip_access #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              datarw_in,
  input  logic              dataena_in,
  input  logic              IP_write_in,
  input  logic              IP_read_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ip_req,
  output logic              ip_we,
  output logic [ADDR_W-1:0] ip_addr,
  output logic [DATA_W-1:0] ip_wdata,
  input  logic              ip_ack,
  input  logic [DATA_W-1:0] ip_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              ip_err
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("ex_ip_access: MEM_LAT must be in 1..15");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("ex_ip_access: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, MEM, IP_REQ, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] lat_cnt;
  logic       ip_strobe;
  logic       any_req;

  assign ip_strobe = IP_write_in | IP_read_in;
  assign any_req   = ip_strobe | dataena_in;

`ifdef IP_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_hit;
  assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ip_strobe)       state_nxt = IP_REQ;
        else if (dataena_in) state_nxt = MEM;
      end
      MEM:    if (lat_cnt == 4'd0) state_nxt = DONE;
      IP_REQ: begin
        if (ip_ack) state_nxt = DONE;
`ifdef IP_TIMEOUT_EN
        else if (timeout_hit) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held off in DONE so the ID/EX register advances while the result is presented.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stall = any_req;
        MEM:     stall = 1'b1;
        IP_REQ:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ip_req      <= 1'b0;
      ip_we       <= 1'b0;
      ip_addr     <= '0;
      ip_wdata    <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      lat_cnt     <= 4'd0;
`ifdef IP_TIMEOUT_EN
      wd_cnt      <= '0;
      ip_err      <= 1'b0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ip_strobe) begin
            ip_req   <= 1'b1;
            ip_we    <= IP_write_in;
            ip_addr  <= address_in;
            ip_wdata <= wdata_in;
`ifdef IP_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
          end else if (dataena_in) begin
            mem_en    <= 1'b1;
            mem_rw    <= datarw_in;
            mem_addr  <= address_in;
            mem_wdata <= wdata_in;
            lat_cnt   <= 4'(MEM_LAT - 1);
          end
        end
        MEM: begin
          if (lat_cnt == 4'd0) begin
            mem_en <= 1'b0;
            if (!mem_rw) begin
              rdata_out   <= mem_rdata;
              rdata_valid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        IP_REQ: begin
          if (ip_ack) begin
            ip_req <= 1'b0;
            if (!ip_we) begin
              rdata_out   <= ip_rdata;
              rdata_valid <= 1'b1;
            end
`ifdef IP_TIMEOUT_EN
          end else if (timeout_hit) begin
            ip_req <= 1'b0;
            ip_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef IP_TIMEOUT_EN
  assign ip_err = 1'b0;
`endif

endmodule

// File: tb/tb_ex_ip_access.sv
// Directed bench for ex_ip_access: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Timeout checks follow IP_TIMEOUT_EN when it is defined for the build.
module tb_ex_ip_access;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address_in;
  logic          datarw_in, dataena1, dataena3, IP_write_in, IP_read_in, ip_ack;
  logic [DW-1:0] wdata_in, mem_rdata, ip_rdata;

  logic          mem_en_1, mem_rw_1, ip_req_1, ip_we_1, stall_1, rdata_valid_1, ip_err_1;
  logic [AW-1:0] mem_addr_1, ip_addr_1;
  logic [DW-1:0] mem_wdata_1, ip_wdata_1, rdata_out_1;
  logic          mem_en_3, mem_rw_3, ip_req_3, ip_we_3, stall_3, rdata_valid_3, ip_err_3;
  logic [AW-1:0] mem_addr_3, ip_addr_3;
  logic [DW-1:0] mem_wdata_3, ip_wdata_3, rdata_out_3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_ip_access #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .TIMEOUT(8)) u_lat1 (
    .clk(clk), .rst(rst), .address_in(address_in), .datarw_in(datarw_in),
    .dataena_in(dataena1), .IP_write_in(IP_write_in), .IP_read_in(IP_read_in),
    .wdata_in(wdata_in), .mem_en(mem_en_1), .mem_rw(mem_rw_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata), .ip_req(ip_req_1), .ip_we(ip_we_1),
    .ip_addr(ip_addr_1), .ip_wdata(ip_wdata_1), .ip_ack(ip_ack), .ip_rdata(ip_rdata),
    .stall(stall_1), .rdata_out(rdata_out_1), .rdata_valid(rdata_valid_1), .ip_err(ip_err_1)
  );

  ex_ip_access #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .TIMEOUT(8)) u_lat3 (
    .clk(clk), .rst(rst), .address_in(address_in), .datarw_in(datarw_in),
    .dataena_in(dataena3), .IP_write_in(IP_write_in), .IP_read_in(IP_read_in),
    .wdata_in(wdata_in), .mem_en(mem_en_3), .mem_rw(mem_rw_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata), .ip_req(ip_req_3), .ip_we(ip_we_3),
    .ip_addr(ip_addr_3), .ip_wdata(ip_wdata_3), .ip_ack(ip_ack), .ip_rdata(ip_rdata),
    .stall(stall_3), .rdata_out(rdata_out_3), .rdata_valid(rdata_valid_3), .ip_err(ip_err_3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; address_in = '0; datarw_in = 1'b0; dataena1 = 1'b0; dataena3 = 1'b0;
    IP_write_in = 1'b0; IP_read_in = 1'b0; ip_ack = 1'b0;
    wdata_in = '0; mem_rdata = '0; ip_rdata = '0;

    // Reset state
    next_cycle(); next_cycle(); settle();
    check("rst_ip_req", ip_req_1, 0);
    check("rst_mem_en", mem_en_1, 0);
    check("rst_stall", stall_1, 0);
    check("rst_rdata_valid", rdata_valid_1, 0);
    check("rst_rdata_out", rdata_out_1, 0);
    check("rst_ip_err", ip_err_1, 0);
    rst = 1'b0;
    next_cycle();

    // Reset asserted mid-handshake with requests still active
    IP_read_in = 1'b1; dataena1 = 1'b1; address_in = 20'h11111; settle();
    check("abort_accept_stall", stall_1, 1);
    next_cycle(); settle();
    check("abort_ip_req_up", ip_req_1, 1);
    #1 rst = 1'b1; #1;
    check("abort_ip_req_async", ip_req_1, 0);
    check("abort_stall_async", stall_1, 0);
    check("abort_mem_en", mem_en_1, 0);
    next_cycle(); IP_read_in = 1'b0; dataena1 = 1'b0; rst = 1'b0; settle();
    check("abort_idle_stall", stall_1, 0);
    next_cycle(); settle();
    check("abort_no_valid", rdata_valid_1, 0);
    check("abort_no_req", ip_req_1, 0);

    // Memory write, MEM_LAT=1
    dataena1 = 1'b1; datarw_in = 1'b1; address_in = 20'h00A5C; wdata_in = 32'hDEADBEEF; settle();
    check("wr_accept_stall", stall_1, 1);
    check("wr_accept_mem_en", mem_en_1, 0);
    next_cycle(); settle();
    check("wr_mem_en", mem_en_1, 1);
    check("wr_mem_rw", mem_rw_1, 1);
    check("wr_mem_addr", mem_addr_1, 20'h00A5C);
    check("wr_mem_wdata", mem_wdata_1, 32'hDEADBEEF);
    check("wr_mem_stall", stall_1, 1);
    next_cycle(); settle();
    check("wr_done_mem_en", mem_en_1, 0);
    check("wr_done_stall", stall_1, 0);
    check("wr_done_no_valid", rdata_valid_1, 0);
    dataena1 = 1'b0; datarw_in = 1'b0;
    next_cycle(); settle();
    check("wr_idle_stall", stall_1, 0);
    check("wr_idle_no_valid", rdata_valid_1, 0);

    // Memory read, MEM_LAT=3; read data valid only on the final MEM cycle
    dataena3 = 1'b1; datarw_in = 1'b0; address_in = 20'h00123; mem_rdata = 32'hBAD0BAD0; settle();
    check("rd3_accept_stall", stall_3, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 2) mem_rdata = 32'h12345678;
      settle();
      check("rd3_mem_en", mem_en_3, 1);
      check("rd3_mem_rw", mem_rw_3, 0);
      check("rd3_mem_addr", mem_addr_3, 20'h00123);
      check("rd3_stall", stall_3, 1);
      check("rd3_no_early_valid", rdata_valid_3, 0);
    end
    next_cycle(); mem_rdata = 32'h0; settle();
    check("rd3_done_valid", rdata_valid_3, 1);
    check("rd3_done_rdata", rdata_out_3, 32'h12345678);
    check("rd3_done_mem_en", mem_en_3, 0);
    check("rd3_done_stall", stall_3, 0);
    dataena3 = 1'b0;
    next_cycle(); settle();
    check("rd3_valid_single", rdata_valid_3, 0);
    check("rd3_rdata_hold", rdata_out_3, 32'h12345678);
    check("rd3_lat1_untouched", rdata_out_1, 0);

    // IP read, ack on the fourth request cycle
    IP_read_in = 1'b1; address_in = 20'hF0F0F; ip_rdata = 32'hBAD1BAD1; settle();
    check("ipr_accept_stall", stall_1, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) begin
        ip_ack = 1'b1; ip_rdata = 32'hCAFE0001;
      end
      settle();
      check("ipr_req", ip_req_1, 1);
      check("ipr_we", ip_we_1, 0);
      check("ipr_addr", ip_addr_1, 20'hF0F0F);
      check("ipr_stall", stall_1, 1);
    end
    next_cycle(); ip_ack = 1'b0; IP_read_in = 1'b0; settle();
    check("ipr_done_valid", rdata_valid_1, 1);
    check("ipr_done_rdata", rdata_out_1, 32'hCAFE0001);
    check("ipr_done_req", ip_req_1, 0);
    check("ipr_done_stall", stall_1, 0);
    check("ipr_lat3_rdata", rdata_out_3, 32'hCAFE0001);
    // A stray ack while idle must be ignored
    next_cycle(); ip_ack = 1'b1; ip_rdata = 32'h0BADF00D; settle();
    check("ipr_valid_single", rdata_valid_1, 0);
    next_cycle(); ip_ack = 1'b0; settle();
    check("stray_ack_rdata", rdata_out_1, 32'hCAFE0001);
    check("stray_ack_valid", rdata_valid_1, 0);
    check("stray_ack_req", ip_req_1, 0);

    // Write and read strobes together, plus a memory request: IP write wins
    IP_write_in = 1'b1; IP_read_in = 1'b1; dataena1 = 1'b1; datarw_in = 1'b0;
    address_in = 20'h00042; wdata_in = 32'h5555AAAA; settle();
    check("prio_accept_stall", stall_1, 1);
    next_cycle(); ip_ack = 1'b1; ip_rdata = 32'h77777777; settle();
    check("prio_ip_req", ip_req_1, 1);
    check("prio_ip_we", ip_we_1, 1);
    check("prio_ip_addr", ip_addr_1, 20'h00042);
    check("prio_ip_wdata", ip_wdata_1, 32'h5555AAAA);
    check("prio_mem_en", mem_en_1, 0);
    next_cycle(); ip_ack = 1'b0; IP_write_in = 1'b0; IP_read_in = 1'b0; dataena1 = 1'b0; settle();
    check("prio_done_req", ip_req_1, 0);
    check("prio_no_valid", rdata_valid_1, 0);
    check("prio_rdata_hold", rdata_out_1, 32'hCAFE0001);
    check("prio_done_mem_en", mem_en_1, 0);
    next_cycle(); settle();
    check("prio_idle_stall", stall_1, 0);

    // Unacknowledged IP read
    IP_read_in = 1'b1; address_in = 20'h00F00; settle();
`ifdef IP_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      next_cycle(); settle();
      check("to_req_held", ip_req_1, 1);
      check("to_err_low", ip_err_1, 0);
    end
    next_cycle(); IP_read_in = 1'b0; settle();
    check("to_req_drop", ip_req_1, 0);
    check("to_err_set", ip_err_1, 1);
    check("to_no_valid", rdata_valid_1, 0);
    check("to_rdata_hold", rdata_out_1, 32'hCAFE0001);
    check("to_done_stall", stall_1, 0);
    next_cycle(); settle();
    check("to_err_sticky", ip_err_1, 1);
`else
    for (int i = 0; i < 20; i++) begin
      next_cycle(); settle();
      check("nto_req_held", ip_req_1, 1);
      check("nto_err_low", ip_err_1, 0);
    end
    ip_ack = 1'b1; ip_rdata = 32'h00C0FFEE;
    next_cycle(); ip_ack = 1'b0; IP_read_in = 1'b0; settle();
    check("nto_late_valid", rdata_valid_1, 1);
    check("nto_late_rdata", rdata_out_1, 32'h00C0FFEE);
    next_cycle(); settle();
`endif

    // Reset during IP_REQ clears the request and the error flag at once
    IP_read_in = 1'b1; address_in = 20'h0ABCD; settle();
    next_cycle(); settle();
    check("rst_ipreq_up", ip_req_1, 1);
    #1 rst = 1'b1; #1;
    check("rst_ipreq_drop", ip_req_1, 0);
    check("rst_ipreq_err", ip_err_1, 0);
    check("rst_ipreq_stall", stall_1, 0);
    next_cycle(); rst = 1'b0; IP_read_in = 1'b0; settle();
    next_cycle(); settle();
    check("post_rst_req", ip_req_1, 0);
    check("post_rst_valid", rdata_valid_1, 0);
    check("post_rst_rdata", rdata_out_1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
